// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state encoding and status-length helper.
package midi_pkg;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_POLY_AT  = 4'hA;
    localparam logic [3:0] ST_CC       = 4'hB;
    localparam logic [3:0] ST_PROG     = 4'hC;
    localparam logic [3:0] ST_CHAN_AT  = 4'hD;
    localparam logic [3:0] ST_BEND     = 4'hE;

    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] SYS_RESET   = 8'hFF;

    localparam logic [13:0] BEND_CENTRE = 14'h2000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SYSEX   = 2'd3
    } state_t;

    // Program change and channel aftertouch carry a single data byte.
    function automatic logic is_two_byte(input logic [3:0] nib);
        return (nib == ST_PROG) || (nib == ST_CHAN_AT);
    endfunction

endpackage

// File: rtl/midi_byte_class.sv
// Combinational MIDI byte classifier; also flags 2-byte channel status bytes.
module midi_byte_class
    import midi_pkg::*;
(
    input  logic [7:0] data,
    output logic       is_realtime,
    output logic       is_common,
    output logic       is_status,
    output logic       is_data,
    output logic       two_byte
);

    always_comb begin
        is_realtime = (data[7:3] == 5'b11111);
        is_common   = (data[7:3] == 5'b11110);
        is_status   = data[7] && (data[7:4] != 4'hF);
        is_data     = !data[7];
        two_byte    = is_status && is_two_byte(data[7:4]);
    end

endmodule

// File: rtl/midi_parser_n.sv
// MIDI byte-stream parser with running status, realtime pass-through,
// channel filtering and SysEx skipping; emits registered one-cycle events.
module midi_parser_n
    import midi_pkg::*;
#(
    parameter logic [15:0] CHAN_MASK   = 16'hFFFF,
    parameter int          VEL0_IS_OFF = 1,
    parameter int          ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_byte,
    input  logic [7:0]        data,
    output logic              note_pressed,
    output logic              note_released,
    output logic              note_keypress,
    output logic              pitch_wheel,
    output logic              ctrl_change,
    output logic [6:0]        note,
    output logic [6:0]        velocity,
    output logic [3:0]        channel,
    output logic [ADDR_W-1:0] addr,
    output logic [13:0]       bend,
    output logic              rst_cmd
);

    state_t     state, state_nxt;
    logic [7:0] status_q;
    logic       status_two_q;
    logic [6:0] d1_q;

    logic is_realtime, is_common, is_status, is_data, two_byte;
    logic ev_prs, ev_rel, ev_kp, ev_pw, ev_cc;

    midi_byte_class u_class (
        .data        (data),
        .is_realtime (is_realtime),
        .is_common   (is_common),
        .is_status   (is_status),
        .is_data     (is_data),
        .two_byte    (two_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Realtime bytes fall through every branch and leave the state untouched.
    always_comb begin
        state_nxt = state;
        if (valid_byte) begin
            if (is_status)
                state_nxt = WAIT_D1;
            else if (is_common)
                state_nxt = (data == SYSEX_START) ? SYSEX : IDLE;
            else if (is_data) begin
                case (state)
                    WAIT_D1: if (!status_two_q) state_nxt = WAIT_D2;
                    WAIT_D2: state_nxt = WAIT_D1;
                    default: state_nxt = state;
                endcase
            end
        end
    end

    always_comb begin
        ev_prs = 1'b0;
        ev_rel = 1'b0;
        ev_kp  = 1'b0;
        ev_pw  = 1'b0;
        ev_cc  = 1'b0;
        if (valid_byte && is_data && state == WAIT_D2 && CHAN_MASK[status_q[3:0]]) begin
            case (status_q[7:4])
                ST_NOTE_OFF: ev_rel = 1'b1;
                ST_NOTE_ON: begin
                    if (data[6:0] == 7'd0 && VEL0_IS_OFF != 0) ev_rel = 1'b1;
                    else                                       ev_prs = 1'b1;
                end
                ST_POLY_AT:  ev_kp = 1'b1;
                ST_CC:       ev_cc = 1'b1;
                ST_BEND:     ev_pw = 1'b1;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q     <= 8'h00;
            status_two_q <= 1'b0;
            d1_q         <= 7'd0;
        end else if (valid_byte) begin
            if (is_status) begin
                status_q     <= data;
                status_two_q <= two_byte;
            end else if (is_common) begin
                status_q     <= 8'h00;
                status_two_q <= 1'b0;
            end else if (is_data && state == WAIT_D1 && !status_two_q)
                d1_q <= data[6:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            note_pressed  <= 1'b0;
            note_released <= 1'b0;
            note_keypress <= 1'b0;
            pitch_wheel   <= 1'b0;
            ctrl_change   <= 1'b0;
            rst_cmd       <= 1'b0;
            note          <= 7'd0;
            velocity      <= 7'd0;
            channel       <= 4'd0;
            addr          <= '0;
            bend          <= BEND_CENTRE;
        end else begin
            note_pressed  <= ev_prs;
            note_released <= ev_rel;
            note_keypress <= ev_kp;
            pitch_wheel   <= ev_pw;
            ctrl_change   <= ev_cc;
            rst_cmd       <= valid_byte && is_realtime && data == SYS_RESET;
            if (ev_prs || ev_rel || ev_kp) begin
                note     <= d1_q;
                velocity <= data[6:0];
            end
            if (ev_cc) begin
                addr     <= ADDR_W'(d1_q);
                velocity <= data[6:0];
            end
            if (ev_pw) bend <= {data[6:0], d1_q};
            if (ev_prs || ev_rel || ev_kp || ev_cc || ev_pw) channel <= status_q[3:0];
        end
    end

endmodule

// File: tb/tb_midi_parser_n.sv
// Directed bench: default parser, a VEL0_IS_OFF=0 variant and a channel-0-only variant share one stream.
module tb_midi_parser_n;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid_byte = 1'b0;
    logic [7:0] data = 8'h00;

    logic       a_prs, a_rel, a_kp, a_pw, a_cc, a_rc;
    logic [6:0] a_note, a_vel;
    logic [3:0] a_ch;
    logic [7:0] a_addr;
    logic [13:0] a_bend;

    logic       b_prs, b_rel, b_kp, b_pw, b_cc, b_rc;
    logic [6:0] b_note, b_vel;
    logic [3:0] b_ch;
    logic [7:0] b_addr;
    logic [13:0] b_bend;

    logic       m_prs, m_rel, m_kp, m_pw, m_cc, m_rc;
    logic [6:0] m_note, m_vel;
    logic [3:0] m_ch;
    logic [7:0] m_addr;
    logic [13:0] m_bend;

    int checks = 0;
    int errors = 0;

    // Pulse vectors ordered {pressed, released, keypress, pitch_wheel, ctrl_change}
    wire [4:0] pa = {a_prs, a_rel, a_kp, a_pw, a_cc};
    wire [4:0] pb = {b_prs, b_rel, b_kp, b_pw, b_cc};
    wire [4:0] pm = {m_prs, m_rel, m_kp, m_pw, m_cc};

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_PRS  = 5'b10000;
    localparam logic [4:0] P_REL  = 5'b01000;
    localparam logic [4:0] P_KP   = 5'b00100;
    localparam logic [4:0] P_PW   = 5'b00010;
    localparam logic [4:0] P_CC   = 5'b00001;

    always #5 clk = ~clk;

    midi_parser_n #(.CHAN_MASK(16'hFFFF), .VEL0_IS_OFF(1), .ADDR_W(8)) u_a (
        .clk(clk), .rst(rst), .valid_byte(valid_byte), .data(data),
        .note_pressed(a_prs), .note_released(a_rel), .note_keypress(a_kp),
        .pitch_wheel(a_pw), .ctrl_change(a_cc), .note(a_note), .velocity(a_vel),
        .channel(a_ch), .addr(a_addr), .bend(a_bend), .rst_cmd(a_rc));

    midi_parser_n #(.CHAN_MASK(16'hFFFF), .VEL0_IS_OFF(0), .ADDR_W(8)) u_b (
        .clk(clk), .rst(rst), .valid_byte(valid_byte), .data(data),
        .note_pressed(b_prs), .note_released(b_rel), .note_keypress(b_kp),
        .pitch_wheel(b_pw), .ctrl_change(b_cc), .note(b_note), .velocity(b_vel),
        .channel(b_ch), .addr(b_addr), .bend(b_bend), .rst_cmd(b_rc));

    midi_parser_n #(.CHAN_MASK(16'h0001), .VEL0_IS_OFF(1), .ADDR_W(8)) u_m (
        .clk(clk), .rst(rst), .valid_byte(valid_byte), .data(data),
        .note_pressed(m_prs), .note_released(m_rel), .note_keypress(m_kp),
        .pitch_wheel(m_pw), .ctrl_change(m_cc), .note(m_note), .velocity(m_vel),
        .channel(m_ch), .addr(m_addr), .bend(m_bend), .rst_cmd(m_rc));

    // One strobe; returns at the negedge after the consuming posedge, when latency-1 outputs are visible.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        valid_byte = 1'b1;
        data       = b;
        @(negedge clk);
        valid_byte = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        valid_byte = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pa !== P_NONE || a_rc !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: got %b rc=%b want %b rc=0", pa, a_rc, P_NONE);
        end
        checks++;
        if (a_note !== 7'd0 || a_vel !== 7'd0 || a_ch !== 4'd0 || a_addr !== 8'd0 || a_bend !== 14'h2000) begin
            errors++; $display("FAIL reset_fields: got note=%h vel=%h ch=%h addr=%h bend=%h want 0 0 0 0 2000",
                               a_note, a_vel, a_ch, a_addr, a_bend);
        end
    endtask

    task automatic test_note_on();
        do_reset();
        send(8'h90); send(8'h3C);
        checks++;
        if (pa !== P_NONE) begin errors++; $display("FAIL note_on_early: got %b want %b", pa, P_NONE); end
        send(8'h64);
        checks++;
        if (pa !== P_PRS || a_note !== 7'd60 || a_vel !== 7'd100 || a_ch !== 4'd0) begin
            errors++; $display("FAIL note_on: got p=%b note=%0d vel=%0d ch=%0d want p=%b 60 100 0",
                               pa, a_note, a_vel, a_ch, P_PRS);
        end
        @(negedge clk);
        checks++;
        if (pa !== P_NONE) begin errors++; $display("FAIL note_on_one_cycle: got %b want %b", pa, P_NONE); end
    endtask

    task automatic test_running_status();
        do_reset();
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'h40); send(8'h00);
        checks++;
        if (pa !== P_REL || a_note !== 7'd64 || a_vel !== 7'd0) begin
            errors++; $display("FAIL run_vel0_off: got p=%b note=%0d vel=%0d want p=%b 64 0", pa, a_note, a_vel, P_REL);
        end
        checks++;
        if (pb !== P_PRS || b_note !== 7'd64 || b_vel !== 7'd0) begin
            errors++; $display("FAIL run_vel0_on: got p=%b note=%0d vel=%0d want p=%b 64 0", pb, b_note, b_vel, P_PRS);
        end
        send(8'h85); send(8'h10); send(8'h05);
        checks++;
        if (pa !== P_REL || a_note !== 7'h10 || a_vel !== 7'h05 || a_ch !== 4'd5) begin
            errors++; $display("FAIL note_off: got p=%b note=%h vel=%h ch=%0d want p=%b 10 05 5", pa, a_note, a_vel, a_ch, P_REL);
        end
    endtask

    task automatic test_realtime();
        do_reset();
        send(8'h91); send(8'hF8);
        checks++;
        if (a_rc !== 1'b0 || pa !== P_NONE) begin
            errors++; $display("FAIL rt_clock: got rc=%b p=%b want rc=0 p=%b", a_rc, pa, P_NONE);
        end
        send(8'h40); send(8'hFF);
        checks++;
        if (a_rc !== 1'b1 || pa !== P_NONE) begin
            errors++; $display("FAIL rt_reset: got rc=%b p=%b want rc=1 p=%b", a_rc, pa, P_NONE);
        end
        send(8'h7F);
        checks++;
        if (pa !== P_PRS || a_note !== 7'd64 || a_vel !== 7'd127 || a_ch !== 4'd1 || a_rc !== 1'b0) begin
            errors++; $display("FAIL rt_note: got p=%b note=%0d vel=%0d ch=%0d rc=%b want p=%b 64 127 1 0",
                               pa, a_note, a_vel, a_ch, a_rc, P_PRS);
        end
    endtask

    task automatic test_bend_cc();
        do_reset();
        send(8'hE2); send(8'h00); send(8'h40);
        checks++;
        if (pa !== P_PW || a_bend !== 14'h2000 || a_ch !== 4'd2) begin
            errors++; $display("FAIL bend_centre: got p=%b bend=%h ch=%0d want p=%b 2000 2", pa, a_bend, a_ch, P_PW);
        end
        send(8'h7F); send(8'h01);
        checks++;
        if (pa !== P_PW || a_bend !== 14'h00FF) begin
            errors++; $display("FAIL bend_order: got p=%b bend=%h want p=%b 00ff", pa, a_bend, P_PW);
        end
        send(8'hB3); send(8'h07); send(8'h55);
        checks++;
        if (pa !== P_CC || a_addr !== 8'd7 || a_vel !== 7'h55 || a_ch !== 4'd3 || a_bend !== 14'h00FF) begin
            errors++; $display("FAIL cc: got p=%b addr=%0d vel=%h ch=%0d bend=%h want p=%b 7 55 3 00ff",
                               pa, a_addr, a_vel, a_ch, a_bend, P_CC);
        end
        send(8'hA4); send(8'h30); send(8'h20);
        checks++;
        if (pa !== P_KP || a_note !== 7'h30 || a_vel !== 7'h20 || a_ch !== 4'd4) begin
            errors++; $display("FAIL keypress: got p=%b note=%h vel=%h ch=%0d want p=%b 30 20 4", pa, a_note, a_vel, a_ch, P_KP);
        end
    endtask

    task automatic test_two_byte();
        logic [4:0] acc;
        do_reset();
        acc = 5'b0;
        send(8'hC0); acc |= pa;
        send(8'h05); acc |= pa;
        send(8'h06); acc |= pa;
        send(8'h07); acc |= pa;
        checks++;
        if (acc !== P_NONE) begin errors++; $display("FAIL prog_change: got %b want %b", acc, P_NONE); end
    endtask

    task automatic test_chan_mask();
        do_reset();
        send(8'h95); send(8'h3C); send(8'h64);
        checks++;
        if (pm !== P_NONE || m_note !== 7'd0 || m_vel !== 7'd0 || m_ch !== 4'd0) begin
            errors++; $display("FAIL mask_block: got p=%b note=%0d vel=%0d ch=%0d want p=%b 0 0 0", pm, m_note, m_vel, m_ch, P_NONE);
        end
        checks++;
        if (pa !== P_PRS || a_ch !== 4'd5) begin
            errors++; $display("FAIL mask_open: got p=%b ch=%0d want p=%b 5", pa, a_ch, P_PRS);
        end
        send(8'h90); send(8'h3C); send(8'h64);
        checks++;
        if (pm !== P_PRS || m_note !== 7'd60 || m_vel !== 7'd100 || m_ch !== 4'd0) begin
            errors++; $display("FAIL mask_pass: got p=%b note=%0d vel=%0d ch=%0d want p=%b 60 100 0", pm, m_note, m_vel, m_ch, P_PRS);
        end
    endtask

    task automatic test_abort_sysex();
        logic [7:0] seq [8] = '{8'h90, 8'h3C, 8'hF0, 8'h01, 8'h02, 8'hF7, 8'h3C, 8'h64};
        logic [4:0] acc;
        do_reset();
        acc = 5'b0;
        for (int i = 0; i < 8; i++) begin
            send(seq[i]);
            acc |= pa;
        end
        checks++;
        if (acc !== P_NONE || a_note !== 7'd0) begin
            errors++; $display("FAIL sysex_skip: got p=%b note=%0d want p=%b 0", acc, a_note, P_NONE);
        end
        send(8'h90); send(8'h3C); send(8'h91); send(8'h40);
        checks++;
        if (pa !== P_NONE) begin errors++; $display("FAIL status_abort: got %b want %b", pa, P_NONE); end
        send(8'h7F);
        checks++;
        if (pa !== P_PRS || a_note !== 7'd64 || a_ch !== 4'd1) begin
            errors++; $display("FAIL after_abort: got p=%b note=%0d ch=%0d want p=%b 64 1", pa, a_note, a_ch, P_PRS);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] acc;
        do_reset();
        send(8'hB3); send(8'h07); send(8'h55);
        send(8'h90);
        do_reset();
        checks++;
        if (a_addr !== 8'd0 || a_vel !== 7'd0 || a_ch !== 4'd0 || a_bend !== 14'h2000) begin
            errors++; $display("FAIL mid_reset_fields: got addr=%0d vel=%h ch=%0d bend=%h want 0 0 0 2000", a_addr, a_vel, a_ch, a_bend);
        end
        acc = 5'b0;
        send(8'h3C); acc |= pa;
        send(8'h64); acc |= pa;
        checks++;
        if (acc !== P_NONE || a_note !== 7'd0) begin
            errors++; $display("FAIL mid_reset_ignore: got p=%b note=%0d want p=%b 0", acc, a_note, P_NONE);
        end
        // rst and a completing data byte in the same cycle: reset wins.
        send(8'h90); send(8'h3C);
        @(negedge clk);
        rst = 1'b1; valid_byte = 1'b1; data = 8'h64;
        @(negedge clk);
        rst = 1'b0; valid_byte = 1'b0;
        checks++;
        if (pa !== P_NONE || a_note !== 7'd0) begin
            errors++; $display("FAIL rst_priority: got p=%b note=%0d want p=%b 0", pa, a_note, P_NONE);
        end
        acc = 5'b0;
        send(8'h40); acc |= pa;
        send(8'h7F); acc |= pa;
        checks++;
        if (acc !== P_NONE) begin errors++; $display("FAIL rst_priority_idle: got %b want %b", acc, P_NONE); end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_realtime();
        test_bend_cc();
        test_two_byte();
        test_chan_mask();
        test_abort_sysex();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
